// File: rtl/fpu_issue_stage_if.sv
// fpu_issue_stage_if: request, FPU-side and response handshake bundle for fpu_issue_stage
//   master: producer/writeback/FPU side (drives req_*, rsp_ready, fpu_result)
//   slave : issue stage side (drives req_ready, fpu_a/b/ctrl, rsp_*, busy)
interface fpu_issue_stage_if #(parameter int RD_W = 4);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [1:0]      req_op;
    logic [RD_W-1:0] req_rd;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic [1:0]      fpu_ctrl;
    logic [31:0]     fpu_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic [RD_W-1:0] rsp_rd;
    logic [3:0]      rsp_flags;
    logic            busy;
    modport master (
        output req_valid, req_a, req_b, req_op, req_rd, fpu_result, rsp_ready,
        input  req_ready, fpu_a, fpu_b, fpu_ctrl, rsp_valid, rsp_result, rsp_rd, rsp_flags, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_rd, fpu_result, rsp_ready,
        output req_ready, fpu_a, fpu_b, fpu_ctrl, rsp_valid, rsp_result, rsp_rd, rsp_flags, busy
    );
endinterface

// File: rtl/fpu_issue_stage.sv
// fpu_issue_stage: holds one FP op on the FPU inputs for LATENCY cycles, then returns result + {N,Z,INF,NAN}
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fpu_issue_stage_if.slave (request, FPU operands/result, response, busy)
module fpu_issue_stage #(
    parameter int LATENCY = 2,
    parameter int RD_W    = 4
) (
    input logic               clk,
    input logic               reset,
    fpu_issue_stage_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_fpu_a;
    logic [31:0]     r_fpu_b;
    logic [1:0]      r_fpu_ctrl;
    logic [RD_W-1:0] r_rd;
    logic [31:0]     r_rsp_result;
    logic [RD_W-1:0] r_rsp_rd;
    logic [3:0]      r_rsp_flags;
    logic            w_ready;
    logic            w_accept;
    logic [31:0]     w_res;
    logic [3:0]      w_flags;
    assign w_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.rsp_ready);
    assign w_accept = bus.req_valid & w_ready;
    assign w_res    = r_fpu_ctrl[0] ? bus.fpu_result : {16'h0, bus.fpu_result[15:0]};
    assign w_flags  = r_fpu_ctrl[0]
        ? {w_res[31], ~|w_res[30:0], &w_res[30:23] & ~|w_res[22:0], &w_res[30:23] & |w_res[22:0]}
        : {w_res[15], ~|w_res[14:0], &w_res[14:10] & ~|w_res[9:0],  &w_res[14:10] & |w_res[9:0]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_ctrl   <= '0;
            r_rd         <= '0;
            r_rsp_result <= '0;
            r_rsp_rd     <= '0;
            r_rsp_flags  <= '0;
        end else if (w_accept) begin
            // half ops present only the low 16 bits to the FPU
            r_fpu_a    <= bus.req_op[0] ? bus.req_a : {16'h0, bus.req_a[15:0]};
            r_fpu_b    <= bus.req_op[0] ? bus.req_b : {16'h0, bus.req_b[15:0]};
            r_fpu_ctrl <= bus.req_op;
            r_rd       <= bus.req_rd;
            r_cnt      <= CW'(LATENCY - 1);
            r_state    <= S_EXEC;
        end else if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_rsp_result <= w_res;
                r_rsp_flags  <= w_flags;
                r_rsp_rd     <= r_rd;
                r_state      <= S_DONE;
            end
        end else if (r_state == S_DONE && bus.rsp_ready) begin
            r_state <= S_IDLE;
        end
    end
    assign bus.req_ready  = w_ready;
    assign bus.fpu_a      = r_fpu_a;
    assign bus.fpu_b      = r_fpu_b;
    assign bus.fpu_ctrl   = r_fpu_ctrl;
    assign bus.rsp_valid  = r_state == S_DONE;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_rd     = r_rsp_rd;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.busy       = r_state != S_IDLE;
endmodule
